// File: rtl/elapsed_timer_if.sv
// Elapsed-timer control/status bundle.
// Signals:
//   tick, start, stop, clear        one-cycle strobes into the timer
//   target_m_tens/m_units/s_tens/s_units   BCD target (mm:ss)
//   m_tens/m_units/s_tens/s_units   registered elapsed-time BCD digits
//   running                         high while the timer is in RUN
//   done                            one-cycle pulse when the target is reached
//   target_error                    one-cycle pulse when start sees an invalid target
// Modports: master drives the strobes and target, slave is the timer.
interface elapsed_timer_if;
    logic       tick;
    logic       start;
    logic       stop;
    logic       clear;
    logic [2:0] target_m_tens;
    logic [3:0] target_m_units;
    logic [2:0] target_s_tens;
    logic [3:0] target_s_units;
    logic [2:0] m_tens;
    logic [3:0] m_units;
    logic [2:0] s_tens;
    logic [3:0] s_units;
    logic       running;
    logic       done;
    logic       target_error;

    modport master (
        output tick, start, stop, clear,
        output target_m_tens, target_m_units, target_s_tens, target_s_units,
        input  m_tens, m_units, s_tens, s_units,
        input  running, done, target_error
    );

    modport slave (
        input  tick, start, stop, clear,
        input  target_m_tens, target_m_units, target_s_tens, target_s_units,
        output m_tens, m_units, s_tens, s_units,
        output running, done, target_error
    );
endinterface

// File: rtl/elapsed_timer.sv
// Elapsed-time counter (mm:ss, BCD) that counts 1 Hz ticks up to a latched target.
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    elapsed_timer_if.slave (strobes, target in; digits, running, done, target_error out)
//
// state | meaning
// IDLE  | count zeroed or cleared, waiting for start
// RUN   | counting ticks toward the latched target
// PAUSE | count held after stop, start resumes with the same target
// DONE  | count holds at the target, start restarts with a new target
module elapsed_timer (
    input  logic                clock,
    input  logic                reset,
    elapsed_timer_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] mt_q, mt_d;
    logic [3:0] mu_q, mu_d;
    logic [2:0] st_q, st_d;
    logic [3:0] su_q, su_d;
    logic [2:0] tmt_q, tmt_d;
    logic [3:0] tmu_q, tmu_d;
    logic [2:0] tst_q, tst_d;
    logic [3:0] tsu_q, tsu_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       tgt_valid;
    logic       tgt_zero;
    logic [2:0] mt_inc;
    logic [3:0] mu_inc;
    logic [2:0] st_inc;
    logic [3:0] su_inc;
    logic       c_su, c_st, c_mu;
    logic       inc_hits;

    // Target validation looks at the live inputs since it only matters on start.
    assign tgt_valid = (bus.target_m_tens  <= 3'd5) && (bus.target_m_units <= 4'd9) &&
                       (bus.target_s_tens  <= 3'd5) && (bus.target_s_units <= 4'd9);
    assign tgt_zero  = (bus.target_m_tens  == 3'd0) && (bus.target_m_units == 4'd0) &&
                       (bus.target_s_tens  == 3'd0) && (bus.target_s_units == 4'd0);

    // One-second BCD increment with cascaded carries; 59:59 wraps to 00:00.
    always_comb begin
        c_su   = (su_q >= 4'd9);
        su_inc = c_su ? 4'd0 : su_q + 4'd1;
        c_st   = c_su && (st_q >= 3'd5);
        st_inc = c_su ? (c_st ? 3'd0 : st_q + 3'd1) : st_q;
        c_mu   = c_st && (mu_q >= 4'd9);
        mu_inc = c_st ? (c_mu ? 4'd0 : mu_q + 4'd1) : mu_q;
        mt_inc = c_mu ? ((mt_q >= 3'd5) ? 3'd0 : mt_q + 3'd1) : mt_q;
    end

    assign inc_hits = (mt_inc == tmt_q) && (mu_inc == tmu_q) &&
                      (st_inc == tst_q) && (su_inc == tsu_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mt_q    <= '0;
            mu_q    <= '0;
            st_q    <= '0;
            su_q    <= '0;
            tmt_q   <= '0;
            tmu_q   <= '0;
            tst_q   <= '0;
            tsu_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mu_q    <= mu_d;
            st_q    <= st_d;
            su_q    <= su_d;
            tmt_q   <= tmt_d;
            tmu_q   <= tmu_d;
            tst_q   <= tst_d;
            tsu_q   <= tsu_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Priority clear > stop > start > tick. Any higher-priority strobe in the
    // same cycle swallows the tick, and ticks outside RUN are simply dropped.
    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        st_d    = st_q;
        su_d    = su_q;
        tmt_d   = tmt_q;
        tmu_d   = tmu_q;
        tst_d   = tst_q;
        tsu_d   = tsu_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            mt_d    = '0;
            mu_d    = '0;
            st_d    = '0;
            su_d    = '0;
        end else if (bus.stop) begin
            if (state_q == RUN)
                state_d = PAUSE;
        end else if (bus.start) begin
            case (state_q)
                IDLE, DONE: begin
                    if (!tgt_valid) begin
                        err_d = 1'b1;
                    end else begin
                        tmt_d = bus.target_m_tens;
                        tmu_d = bus.target_m_units;
                        tst_d = bus.target_s_tens;
                        tsu_d = bus.target_s_units;
                        mt_d  = '0;
                        mu_d  = '0;
                        st_d  = '0;
                        su_d  = '0;
                        if (tgt_zero) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                PAUSE:   state_d = RUN;
                default: ;
            endcase
        end else if (bus.tick && (state_q == RUN)) begin
            mt_d = mt_inc;
            mu_d = mu_inc;
            st_d = st_inc;
            su_d = su_inc;
            if (inc_hits) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    assign bus.m_tens       = mt_q;
    assign bus.m_units      = mu_q;
    assign bus.s_tens       = st_q;
    assign bus.s_units      = su_q;
    assign bus.running      = (state_q == RUN);
    assign bus.done         = done_q;
    assign bus.target_error = err_q;

endmodule

// File: tb/tb_elapsed_timer.sv
// Directed bench for elapsed_timer: a vector table for the single-cycle
// behaviour plus hand-written long-run and corner sequences.
module tb_elapsed_timer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    elapsed_timer_if bus ();

    elapsed_timer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        tick;
        logic        start;
        logic        stop;
        logic        clear;
        logic [13:0] tgt;
        logic [13:0] exp_t;
        logic        exp_run;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [13:0] bcd(int mt, int mu, int st, int su);
        logic [2:0] a;
        logic [3:0] b;
        logic [2:0] c;
        logic [3:0] d;
        a = 3'(mt);
        b = 4'(mu);
        c = 3'(st);
        d = 4'(su);
        return {a, b, c, d};
    endfunction

    // Drive inputs just after a rising edge, then advance one edge and settle.
    task automatic cyc(input logic tk, input logic sa, input logic sp,
                       input logic cl, input logic [13:0] tg);
        bus.tick           = tk;
        bus.start          = sa;
        bus.stop           = sp;
        bus.clear          = cl;
        bus.target_m_tens  = tg[13:11];
        bus.target_m_units = tg[10:7];
        bus.target_s_tens  = tg[6:4];
        bus.target_s_units = tg[3:0];
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [13:0] et,
                         input logic er, input logic ed, input logic ee);
        logic [13:0] at;
        at = {bus.m_tens, bus.m_units, bus.s_tens, bus.s_units};
        n_cmp++;
        if (at !== et || bus.running !== er || bus.done !== ed || bus.target_error !== ee) begin
            n_fail++;
            $display("FAIL %s: got time=%h run=%b done=%b err=%b, want time=%h run=%b done=%b err=%b",
                     name, at, bus.running, bus.done, bus.target_error, et, er, ed, ee);
        end
    endtask

    vec_t vecs[22];

    initial begin
        int early;
        logic [13:0] z;
        z = 14'd0;

        //               tk    st    sp    cl    target          expected time   run   done  err
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, z,              z,              1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, bcd(0,0,0,3),   z,              1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, z,              bcd(0,0,0,1),   1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, z,              bcd(0,0,0,2),   1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, z,              bcd(0,0,0,2),   1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, z,              bcd(0,0,0,3),   1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, z,              bcd(0,0,0,3),   1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, z,              bcd(0,0,0,3),   1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, bcd(0,10,0,0),  bcd(0,0,0,3),   1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, z,              bcd(0,0,0,3),   1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, z,              z,              1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, bcd(0,0,1,0),   z,              1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, z,              z,              1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, z,              z,              1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, bcd(0,0,0,1),   z,              1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, z,              bcd(0,0,0,1),   1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, z,              bcd(0,0,0,1),   1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, z,              bcd(0,0,0,1),   1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, z,              bcd(0,0,0,1),   1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, z,              z,              1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, bcd(6,0,0,0),   z,              1'b0, 1'b0, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, z,              z,              1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        cyc(0, 0, 0, 0, z);
        cyc(0, 0, 0, 0, z);
        check("reset_state", z, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            cyc(vecs[i].tick, vecs[i].start, vecs[i].stop, vecs[i].clear, vecs[i].tgt);
            check($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_run,
                  vecs[i].exp_done, vecs[i].exp_err);
        end

        // Minute carries toward a 02:00 target.
        cyc(0, 1, 0, 0, bcd(0,2,0,0));
        early = 0;
        for (int i = 0; i < 59; i++) begin
            cyc(1, 0, 0, 0, z);
            if (bus.done) early++;
        end
        check("t0200_at_0059", bcd(0,0,5,9), 1, 0, 0);
        cyc(1, 0, 0, 0, z);
        check("t0200_at_0100", bcd(0,1,0,0), 1, 0, 0);
        for (int i = 0; i < 59; i++) begin
            cyc(1, 0, 0, 0, z);
            if (bus.done) early++;
        end
        check("t0200_at_0159", bcd(0,1,5,9), 1, 0, 0);
        cyc(1, 0, 0, 0, z);
        check("t0200_done", bcd(0,2,0,0), 0, 1, 0);
        n_cmp++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL t0200_early_done: got %0d early pulses, want 0", early);
        end

        // Full hour run to 59:59, then a zero-target restart.
        cyc(0, 1, 0, 0, bcd(5,9,5,9));
        early = 0;
        for (int i = 0; i < 3598; i++) begin
            cyc(1, 0, 0, 0, z);
            if (bus.done || !bus.running) early++;
        end
        check("t5959_at_5958", bcd(5,9,5,8), 1, 0, 0);
        n_cmp++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL t5959_early_stop: got %0d bad cycles, want 0", early);
        end
        cyc(1, 0, 0, 0, z);
        check("t5959_done", bcd(5,9,5,9), 0, 1, 0);
        cyc(0, 1, 0, 0, z);
        check("zero_target_done", z, 0, 1, 0);

        // stop+tick, ticks during PAUSE, resume.
        cyc(0, 1, 0, 0, bcd(0,0,1,0));
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, z);
        check("pause_at_0005", bcd(0,0,0,5), 1, 0, 0);
        cyc(1, 0, 1, 0, z);
        check("stop_tick", bcd(0,0,0,5), 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, z);
        check("paused_ticks", bcd(0,0,0,5), 0, 0, 0);
        cyc(0, 1, 0, 0, z);
        check("resume", bcd(0,0,0,5), 1, 0, 0);
        cyc(1, 0, 0, 0, z);
        check("resume_tick", bcd(0,0,0,6), 1, 0, 0);

        // clear beats start; reset beats everything mid-RUN.
        cyc(1, 0, 0, 0, z);
        check("at_0007", bcd(0,0,0,7), 1, 0, 0);
        cyc(1, 1, 0, 1, bcd(0,0,0,5));
        check("clear_start", z, 0, 0, 0);
        cyc(0, 1, 0, 0, bcd(0,0,0,5));
        cyc(1, 0, 0, 0, z);
        check("run_after_clear", bcd(0,0,0,1), 1, 0, 0);
        reset = 1'b1;
        cyc(1, 1, 0, 0, bcd(0,0,0,2));
        check("reset_mid_run", z, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 1, 0, 0, bcd(0,0,0,1));
        check("start_after_reset", z, 1, 0, 0);
        cyc(1, 0, 0, 0, z);
        check("done_after_reset", bcd(0,0,0,1), 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
